// File: rtl/dmux_8way_arbiter.sv
// rtl/dmux_8way_arbiter.sv - round-robin owner arbiter for a shared 8-way dmux lane
module dmux_8way_arbiter #(
    parameter int MAX_HOLD = 15,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] req,
    input  logic       done,
    output logic [2:0] sel,
    output logic [7:0] grant,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    state_t           state, state_nx;
    logic [2:0]       ptr, ptr_nx;
    logic [2:0]       sel_nx;
    logic [7:0]       grant_nx;
    logic             busy_nx, timeout_nx;
    logic [CNT_W-1:0] hold_cnt, hold_nx;

    logic       found;
    logic [2:0] win;
    logic [2:0] idx;

    // Round-robin scan: first active request at or after ptr, wrapping modulo 8.
    always_comb begin
        found = 1'b0;
        win   = ptr;
        idx   = 3'd0;
        for (int k = 0; k < 8; k++) begin
            idx = ptr + 3'(k);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    // Next-state and next-output decode; every output is taken from a register.
    always_comb begin
        state_nx   = state;
        ptr_nx     = ptr;
        sel_nx     = sel;
        grant_nx   = grant;
        busy_nx    = busy;
        timeout_nx = 1'b0;
        hold_nx    = hold_cnt;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nx = GRANT;
                    sel_nx   = win;
                    grant_nx = 8'b1 << win;
                    busy_nx  = 1'b1;
                    hold_nx  = '0;
                end
            end
            GRANT: begin
                if (done || !req[sel]) begin
                    // Voluntary release wins over expiry, so no timeout pulse here.
                    state_nx = RELEASE;
                    grant_nx = 8'h00;
                    ptr_nx   = sel + 3'd1;
                    hold_nx  = '0;
                end else if (hold_cnt == HOLD_LAST) begin
                    state_nx   = RELEASE;
                    grant_nx   = 8'h00;
                    ptr_nx     = sel + 3'd1;
                    hold_nx    = '0;
                    timeout_nx = 1'b1;
                end else begin
                    hold_nx = hold_cnt + 1'b1;
                end
            end
            RELEASE: begin
                // Dead cycle: lane stays unowned so ownership never switches back-to-back.
                state_nx = IDLE;
                busy_nx  = 1'b0;
            end
            default: begin
                state_nx = IDLE;
                grant_nx = 8'h00;
                busy_nx  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset clears everything immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            ptr      <= 3'd0;
            sel      <= 3'd0;
            grant    <= 8'h00;
            busy     <= 1'b0;
            timeout  <= 1'b0;
            hold_cnt <= '0;
        end else begin
            state    <= state_nx;
            ptr      <= ptr_nx;
            sel      <= sel_nx;
            grant    <= grant_nx;
            busy     <= busy_nx;
            timeout  <= timeout_nx;
            hold_cnt <= hold_nx;
        end
    end

endmodule
